// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port word RAM between a fetch port and a data port.
// Define RAM_ARBITER_ALIGN_CHECK_EN to reject misaligned byte addresses with an error ack.
`timescale 1ns/1ps

module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH+1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH+1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_rd,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_rd_q, ram_rd_d;
  logic                  ram_oe_q, ram_oe_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic                  if_err_q, if_err_d, dm_err_q, dm_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                  busy_q, busy_d;

  logic win_dm;
  logic mis_sel;

`ifndef RAM_ARBITER_ALIGN_CHECK_EN
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};
`endif

  // Outputs are registered off the current state, so each phase reaches the
  // pins one cycle after the state register enters it.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    rr_d        = rr_q;
    port_d      = port_q;
    we_d        = we_q;
    mis_d       = mis_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_cs_d    = 1'b0;
    ram_rd_d    = 1'b0;
    ram_oe_d    = 1'b0;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    win_dm = dm_req & (~if_req | (rr_q == PORT_DM));
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
    mis_sel = win_dm ? (dm_addr[1:0] != 2'b00) : (if_addr[1:0] != 2'b00);
`else
    mis_sel = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          port_d  = win_dm ? PORT_DM : PORT_IF;
          rr_d    = win_dm ? PORT_IF : PORT_DM;
          addr_d  = win_dm ? dm_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
          we_d    = win_dm & dm_we;
          wdata_d = win_dm ? dm_wdata : '0;
          mis_d   = mis_sel;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_cs_d    = ~mis_q;
        ram_rd_d    = ~mis_q & ~we_q;
        ram_oe_d    = ~mis_q & ~we_q;
        ram_addr_d  = addr_q;
        ram_wdata_d = wdata_q;
        state_d     = RESP;
      end
      RESP: begin
        // RAM data is valid this cycle; capture it alongside the ack.
        if_ack_d = (port_q == PORT_IF);
        dm_ack_d = (port_q == PORT_DM);
        if_err_d = mis_q & (port_q == PORT_IF);
        dm_err_d = mis_q & (port_q == PORT_DM);
        if (!we_q && !mis_q) begin
          if (port_q == PORT_IF) if_rdata_d = ram_read_data;
          else                   dm_rdata_d = ram_read_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= PORT_IF;
      port_q      <= PORT_IF;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_cs_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_cs_q    <= ram_cs_d;
      ram_rd_q    <= ram_rd_d;
      ram_oe_q    <= ram_oe_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_err_q    <= if_err_d;
      dm_err_q    <= dm_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_addr       = ram_addr_q;
  assign ram_cs         = ram_cs_q;
  assign ram_rd         = ram_rd_q;
  assign ram_oe         = ram_oe_q;
  assign ram_write_data = ram_wdata_q;
  assign if_ack         = if_ack_q;
  assign dm_ack         = dm_ack_q;
  assign if_err         = if_err_q;
  assign dm_err         = dm_err_q;
  assign if_rdata       = if_rdata_q;
  assign dm_rdata       = dm_rdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1K x 32 RAM.
// Build with RAM_ARBITER_ALIGN_CHECK_EN defined to exercise the alignment check.
`timescale 1ns/1ps

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [11:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic [9:0]  ram_addr;
  logic        ram_cs, ram_rd, ram_oe;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_oe(ram_oe),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .busy(busy)
  );

  // Word i starts as A500_0000 | i; writes land on the posedge ending a cs/write cycle.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    forever begin
      @(posedge clk);
      if (ram_cs && !ram_rd) mem[ram_addr] = ram_write_data;
    end
  end

  assign ram_read_data = (ram_cs && ram_rd && ram_oe) ? mem[ram_addr] : 32'h0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request: drive, check the RAM cycle, the ack cycle and the ack drop.
  task automatic access(input bit is_dm, input bit we, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rdata,
                        input bit exp_cs, input bit exp_err, input string tag);
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    tick();
    check({tag, ":cs_early"}, ram_cs, 0);
    tick();
    check({tag, ":cs"}, ram_cs, exp_cs);
    check({tag, ":busy"}, busy, 1);
    if (exp_cs) begin
      check({tag, ":rd"}, ram_rd, !we);
      check({tag, ":oe"}, ram_oe, !we);
      check({tag, ":ram_addr"}, ram_addr, a[11:2]);
      if (we) check({tag, ":wdata"}, ram_write_data, wd);
    end
    check({tag, ":ack_early"}, is_dm ? dm_ack : if_ack, 0);
    tick();
    check({tag, ":ack"}, is_dm ? dm_ack : if_ack, 1);
    check({tag, ":other_ack"}, is_dm ? if_ack : dm_ack, 0);
    check({tag, ":err"}, is_dm ? dm_err : if_err, exp_err);
    check({tag, ":rdata"}, is_dm ? dm_rdata : if_rdata, exp_rdata);
    check({tag, ":cs_resp"}, ram_cs, 0);
    if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
    tick();
    check({tag, ":ack_drop"}, is_dm ? dm_ack : if_ack, 0);
  endtask

  initial begin
    // Reset and idle
    repeat (3) tick();
    check("rst:ram_cs", ram_cs, 0);
    check("rst:ram_rd", ram_rd, 0);
    check("rst:ram_oe", ram_oe, 0);
    check("rst:ram_addr", ram_addr, 0);
    check("rst:ram_wdata", ram_write_data, 0);
    check("rst:acks", {if_ack, dm_ack}, 0);
    check("rst:errs", {if_err, dm_err}, 0);
    check("rst:if_rdata", if_rdata, 0);
    check("rst:dm_rdata", dm_rdata, 0);
    check("rst:busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle:busy", busy, 0);
    check("idle:ram_cs", ram_cs, 0);

    // dm write then read at byte 0x010 (word 4)
    access(1, 1, 12'h010, 32'hDEAD_BEEF, 32'h0, 1, 0, "dm_wr10");
    access(1, 0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1, 0, "dm_rd10");
    check("dm_rd10:if_rdata", if_rdata, 0);

    // Contention held over four requests: if, dm, if, dm with acks 3 cycles apart
    if_req = 1'b1; if_addr = 12'h000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h008;
    tick(); tick();
    check("rr1:ram_addr", ram_addr, 10'd0);
    check("rr1:acks_early", {if_ack, dm_ack}, 2'b00);
    tick();
    check("rr1:acks", {if_ack, dm_ack}, 2'b10);
    check("rr1:if_rdata", if_rdata, 32'hA500_0000);
    if_addr = 12'h004;
    tick(); tick();
    check("rr2:ram_addr", ram_addr, 10'd2);
    check("rr2:acks_early", {if_ack, dm_ack}, 2'b00);
    tick();
    check("rr2:acks", {if_ack, dm_ack}, 2'b01);
    check("rr2:dm_rdata", dm_rdata, 32'hA500_0002);
    dm_addr = 12'h00C;
    tick(); tick();
    check("rr3:ram_addr", ram_addr, 10'd1);
    check("rr3:acks_early", {if_ack, dm_ack}, 2'b00);
    tick();
    check("rr3:acks", {if_ack, dm_ack}, 2'b10);
    check("rr3:if_rdata", if_rdata, 32'hA500_0001);
    if_req = 1'b0;
    tick(); tick();
    check("rr4:ram_addr", ram_addr, 10'd3);
    check("rr4:acks_early", {if_ack, dm_ack}, 2'b00);
    tick();
    check("rr4:acks", {if_ack, dm_ack}, 2'b01);
    check("rr4:dm_rdata", dm_rdata, 32'hA500_0003);
    dm_req = 1'b0;
    tick();
    check("rr4:acks_drop", {if_ack, dm_ack}, 2'b00);
    check("rr4:busy", busy, 0);

    // Top word: byte 0xFFC is word 1023; a write leaves dm_rdata alone
    access(1, 1, 12'hFFC, 32'h1234_5678, 32'hA500_0003, 1, 0, "dm_wrFFC");
    check("dm_wrFFC:ram_addr_last", ram_addr, 10'd1023);
    access(1, 0, 12'hFFC, 32'h0, 32'h1234_5678, 1, 0, "dm_rdFFC");

    // Reset during the RAM cycle of a fetch
    if_req = 1'b1; if_addr = 12'h004;
    tick(); tick();
    check("abort:cs_before", ram_cs, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort:cs_async", ram_cs, 0);
    check("abort:rd_async", ram_rd, 0);
    check("abort:busy", busy, 0);
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort:no_ack", {if_ack, dm_ack}, 2'b00);
    check("abort:idle", busy, 0);
    check("abort:if_rdata", if_rdata, 0);
    access(0, 0, 12'h004, 32'h0, 32'hA500_0001, 1, 0, "if_after_rst");

    // Misaligned data read at 0x011
    access(1, 0, 12'h00C, 32'h0, 32'hA500_0003, 1, 0, "dm_rd0C");
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
    access(1, 0, 12'h011, 32'h0, 32'hA500_0003, 0, 1, "dm_mis11");
`else
    access(1, 0, 12'h011, 32'h0, 32'hDEAD_BEEF, 1, 0, "dm_mis11");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
